// File: rtl/hamming_reg_loader.sv
// -----------------------------------------------------------------------------
// hamming_reg_loader
//
// Upstream sequencer for the Hamming-protected shift register. Words are
// accepted over a valid/ready handshake and written into the register either
// serially (WIDTH shift cycles, mode 00 or 01) or in one cycle (mode 11,
// load=1). With readback enabled, the corrected parallel_out is compared with
// the word after loading. A difference means the register has a fault that
// its single-bit correction cannot repair.
//
// Build option:
//   HAMMING_LOADER_READBACK_EN  defined   -> SETTLE + CHECK states, mismatch live
//                               undefined -> done follows the last load cycle,
//                                            mismatch tied low
//
// Parameters:
//   WIDTH  data width. It must match the register, be a multiple of 4 and be
//          at least 8.
//   CNT_W  bit-counter width. It is derived from WIDTH and is not overridden.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   s_valid/s_ready     upstream handshake
//   s_data              word to load
//   s_dir               0: right shift (bit enters MSB), 1: left shift
//   s_fast              1: single-cycle parallel load (overrides s_dir)
//   reg_enable, reg_mode, reg_load, reg_serial_in, reg_parallel_in
//                       drive the protected register
//   reg_parallel_out    corrected register contents (readback)
//   busy                state is not IDLE
//   done                one-cycle pulse when a word load completes
//   mismatch            readback differed; held until the next accept
// -----------------------------------------------------------------------------
module hamming_reg_loader #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_dir,
    input  logic             s_fast,
    output logic             reg_enable,
    output logic [1:0]       reg_mode,
    output logic             reg_load,
    output logic             reg_serial_in,
    output logic [WIDTH-1:0] reg_parallel_in,
    input  logic [WIDTH-1:0] reg_parallel_out,
    output logic             busy,
    output logic             done,
    output logic             mismatch
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SHIFT  = 3'd2;
`ifdef HAMMING_LOADER_READBACK_EN
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_CHECK  = 3'd4;
    // State entered after the final LOAD/SHIFT cycle
    localparam logic [2:0] ST_AFTER  = ST_SETTLE;
`else
    localparam logic [2:0] ST_AFTER  = ST_IDLE;
`endif

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shadow;
    logic             r_dir;
    logic             w_ready;
    logic             w_accept;
    logic             w_last_shift;
    logic [1:0]       w_mode;
`ifdef HAMMING_LOADER_READBACK_EN
    logic             r_mismatch;
`else
    logic             r_done;
    logic             w_unused_readback;
`endif

    // Serial bit for the current count. A left shift feeds the MSB first and a
    // right shift feeds the LSB first, so the word lands unreversed.
    function automatic logic f_serial_bit(input logic [WIDTH-1:0] word,
                                          input logic [CNT_W-1:0] cnt,
                                          input logic             dir);
        logic [CNT_W-1:0] idx;
        if (dir) begin
            idx = CNT_LAST - cnt;
        end else begin
            idx = cnt;
        end
        return word[idx];
    endfunction

    // s_ready is gated by rst so that it reads 0 for the whole reset period.
    assign w_ready      = (r_state == ST_IDLE) && !rst;
    assign w_accept     = s_valid && w_ready;
    assign w_last_shift = (r_state == ST_SHIFT) && (r_cnt == CNT_LAST);

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = s_fast ? ST_LOAD : ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_AFTER;
            end
            ST_SHIFT: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_AFTER;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
`ifdef HAMMING_LOADER_READBACK_EN
            ST_SETTLE: begin
                w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                w_state_nxt = ST_IDLE;
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counter, shadow word and readback flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= {CNT_W{1'b0}};
            r_shadow   <= {WIDTH{1'b0}};
            r_dir      <= 1'b0;
`ifdef HAMMING_LOADER_READBACK_EN
            r_mismatch <= 1'b0;
`else
            r_done     <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
`ifndef HAMMING_LOADER_READBACK_EN
            // Without readback, done lands in the IDLE cycle after the last load cycle.
            r_done  <= (r_state == ST_LOAD) || w_last_shift;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shadow   <= s_data;
                        r_dir      <= s_dir;
                        r_cnt      <= {CNT_W{1'b0}};
`ifdef HAMMING_LOADER_READBACK_EN
                        r_mismatch <= 1'b0;
`endif
                    end
                end
                ST_SHIFT: begin
                    // Explicit wrap: WIDTH need not be a power of two.
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= {CNT_W{1'b0}};
                    end else begin
                        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
`ifdef HAMMING_LOADER_READBACK_EN
                ST_CHECK: begin
                    r_mismatch <= (reg_parallel_out != r_shadow);
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // Register pin decode. Only state flops feed it, so there is no path from s_* inputs.
    always_comb begin
        reg_enable      = 1'b0;
        w_mode          = 2'b11;
        reg_load        = 1'b0;
        reg_serial_in   = 1'b0;
        reg_parallel_in = {WIDTH{1'b0}};
        case (r_state)
            ST_LOAD: begin
                reg_enable      = 1'b1;
                reg_load        = 1'b1;
                reg_parallel_in = r_shadow;
            end
            ST_SHIFT: begin
                reg_enable    = 1'b1;
                w_mode        = {1'b0, r_dir};
                reg_serial_in = f_serial_bit(r_shadow, r_cnt, r_dir);
            end
            default: begin
                // Mode 11 with load=0 holds the register.
                w_mode = 2'b11;
            end
        endcase
    end

    // The idle mode is the hold code 11, but every output must read 0 during reset.
    assign reg_mode = rst ? 2'b00 : w_mode;
    assign s_ready  = w_ready;
    assign busy     = (r_state != ST_IDLE);

`ifdef HAMMING_LOADER_READBACK_EN
    assign done     = (r_state == ST_CHECK);
    assign mismatch = r_mismatch;
`else
    assign done              = r_done;
    assign mismatch          = 1'b0;
    assign w_unused_readback = ^reg_parallel_out;
`endif

endmodule

// File: tb/tb_hamming_reg_loader.sv
module tb_hamming_reg_loader;

    localparam int WIDTH = 16;
`ifdef HAMMING_LOADER_READBACK_EN
    localparam int DONE_SER  = WIDTH + 2;
    localparam int DONE_FAST = 3;
    localparam int SPACING   = WIDTH + 3;
`else
    localparam int DONE_SER  = WIDTH + 1;
    localparam int DONE_FAST = 2;
    localparam int SPACING   = WIDTH + 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [WIDTH-1:0] s_data = 16'h0000;
    logic             s_dir = 1'b0;
    logic             s_fast = 1'b0;
    logic             reg_enable;
    logic [1:0]       reg_mode;
    logic             reg_load;
    logic             reg_serial_in;
    logic [WIDTH-1:0] reg_parallel_in;
    logic [WIDTH-1:0] reg_parallel_out;
    logic             busy;
    logic             done;
    logic             mismatch;

    // Behavioural stand-in for the protected register (no ECC), plus a fault override.
    logic [WIDTH-1:0] model_q = 16'h0000;
    logic             fault_en = 1'b0;
    logic [WIDTH-1:0] fault_val = 16'h0000;

    int n_checks = 0;
    int n_pass   = 0;

    hamming_reg_loader #(.WIDTH(WIDTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .s_dir            (s_dir),
        .s_fast           (s_fast),
        .reg_enable       (reg_enable),
        .reg_mode         (reg_mode),
        .reg_load         (reg_load),
        .reg_serial_in    (reg_serial_in),
        .reg_parallel_in  (reg_parallel_in),
        .reg_parallel_out (reg_parallel_out),
        .busy             (busy),
        .done             (done),
        .mismatch         (mismatch)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reg_enable) begin
            case (reg_mode)
                2'b00: model_q <= {reg_serial_in, model_q[WIDTH-1:1]};
                2'b01: model_q <= {model_q[WIDTH-2:0], reg_serial_in};
                2'b11: if (reg_load) model_q <= reg_parallel_in;
                default: model_q <= model_q;
            endcase
        end
    end

    assign reg_parallel_out = fault_en ? fault_val : model_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one word in an IDLE cycle and steps over the accept edge.
    task automatic send(input logic [WIDTH-1:0] d, input logic dir, input logic fast);
        s_data  = d;
        s_dir   = dir;
        s_fast  = fast;
        s_valid = 1'b1;
        chk("ready_before_accept", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"},  32'(s_ready), 32'd0);
        chk({tag, "_en"},     32'(reg_enable), 32'd0);
        chk({tag, "_mode"},   32'(reg_mode), 32'd0);
        chk({tag, "_load"},   32'(reg_load), 32'd0);
        chk({tag, "_sin"},    32'(reg_serial_in), 32'd0);
        chk({tag, "_pin"},    32'(reg_parallel_in), 32'd0);
        chk({tag, "_busy"},   32'(busy), 32'd0);
        chk({tag, "_done"},   32'(done), 32'd0);
        chk({tag, "_mism"},   32'(mismatch), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] word;
        logic [WIDTH-1:0] hs_words [3];
        int cyc;
        int idx;
        int n_acc;
        int n_done;
        int done_cyc [3];

        // ---- Reset state
        #2;
        chk_all_zero("por");
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("idle_ready", 32'(s_ready), 32'd1);
        chk("idle_mode_hold", 32'(reg_mode), 32'd3);
        chk("idle_busy", 32'(busy), 32'd0);

        // ---- Serial right, 16'hA5C3: LSB first, mode 00
        word = 16'hA5C3;
        send(word, 1'b0, 1'b0);
        chk("sr_bit0", 32'(reg_serial_in), 32'd1);
        for (int i = 0; i < WIDTH; i++) begin
            chk("sr_en", 32'(reg_enable), 32'd1);
            chk("sr_mode", 32'(reg_mode), 32'd0);
            chk("sr_bit", 32'(reg_serial_in), 32'(word[i]));
            chk("sr_done_low", 32'(done), 32'd0);
            tick();
        end
        // Now in cycle WIDTH+1
        chk("sr_en_off", 32'(reg_enable), 32'd0);
        chk("sr_model", 32'(reg_parallel_out), 32'hA5C3);
`ifdef HAMMING_LOADER_READBACK_EN
        chk("sr_settle_done", 32'(done), 32'd0);
        chk("sr_settle_busy", 32'(busy), 32'd1);
        tick();
`endif
        chk("sr_done_cycle", 32'(done), 32'd1);
        tick();
        chk("sr_done_pulse", 32'(done), 32'd0);
        chk("sr_mismatch", 32'(mismatch), 32'd0);
        chk("sr_ready_after", 32'(s_ready), 32'd1);

        // ---- Serial left, 16'h8001: MSB first, mode 01
        word = 16'h8001;
        send(word, 1'b1, 1'b0);
        for (int i = 0; i < WIDTH; i++) begin
            chk("sl_mode", 32'(reg_mode), 32'd1);
            chk("sl_bit", 32'(reg_serial_in), ((i == 0) || (i == WIDTH - 1)) ? 32'd1 : 32'd0);
            tick();
        end
        chk("sl_model", 32'(reg_parallel_out), 32'h8001);
        for (int i = WIDTH + 1; i <= DONE_SER; i++) tick();
        chk("sl_mismatch", 32'(mismatch), 32'd0);

        // ---- Fast load, 16'h1234
        send(16'h1234, 1'b1, 1'b1);
        chk("fl_en", 32'(reg_enable), 32'd1);
        chk("fl_mode", 32'(reg_mode), 32'd3);
        chk("fl_load", 32'(reg_load), 32'd1);
        chk("fl_pin", 32'(reg_parallel_in), 32'h1234);
        tick();
        chk("fl_load_off", 32'(reg_load), 32'd0);
        chk("fl_pin_off", 32'(reg_parallel_in), 32'h0000);
        // Corrupt the readback ahead of CHECK.
        fault_en  = 1'b1;
        fault_val = 16'h1235;
        if (DONE_FAST == 3) begin
            chk("fl_settle_done", 32'(done), 32'd0);
            tick();
        end
        chk("fl_done_cycle", 32'(done), 32'd1);
        tick();
        tick();
        tick();
`ifdef HAMMING_LOADER_READBACK_EN
        chk("rb_mismatch_set", 32'(mismatch), 32'd1);
`else
        chk("rb_mismatch_tied", 32'(mismatch), 32'd0);
`endif
        fault_en = 1'b0;
        send(16'h00FF, 1'b0, 1'b1);
        chk("rb_mismatch_clear", 32'(mismatch), 32'd0);
        for (int i = 1; i < DONE_FAST + 1; i++) tick();
        chk("rb_clean_model", 32'(reg_parallel_out), 32'h00FF);
        chk("rb_clean_mismatch", 32'(mismatch), 32'd0);

        // ---- Reset mid-SHIFT (cnt = 5)
        send(16'hFFFF, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        chk("rs_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk_all_zero("rs_async");
        tick();
        chk_all_zero("rs_held");
        rst = 1'b0;
        #1;
        chk("rs_ready_after", 32'(s_ready), 32'd1);
        chk("rs_busy_after", 32'(busy), 32'd0);
        chk("rs_mode_after", 32'(reg_mode), 32'd3);

        // ---- Handshake: s_valid held high across three words
        hs_words[0] = 16'h0001;
        hs_words[1] = 16'h0002;
        hs_words[2] = 16'h0003;
        idx    = 0;
        n_acc  = 0;
        n_done = 0;
        s_dir  = 1'b0;
        s_fast = 1'b0;
        for (cyc = 0; cyc < 4 * SPACING; cyc++) begin
            s_valid = (idx < 3);
            s_data  = (idx < 3) ? hs_words[idx] : 16'h0000;
            if (done) begin
                if (n_done < 3) begin
                    done_cyc[n_done] = cyc;
                    chk("hs_word_at_done", 32'(reg_parallel_out), 32'(hs_words[n_done]));
                end
                n_done++;
            end
            if (s_valid && s_ready) begin
                n_acc++;
                idx++;
            end
            tick();
        end
        s_valid = 1'b0;
        chk("hs_accepts", 32'(n_acc), 32'd3);
        chk("hs_dones", 32'(n_done), 32'd3);
        if (n_done >= 3) begin
            chk("hs_space01", 32'(done_cyc[1] - done_cyc[0]), 32'(SPACING));
            chk("hs_space12", 32'(done_cyc[2] - done_cyc[1]), 32'(SPACING));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hamming_reg_loader.md
Name: hamming_reg_loader

Overview:
- Upstream sequencer for the Hamming-protected shift register (the 16-bit, 4-bit-block SEC register).
- Accepts whole words over a valid/ready handshake and drives that register's enable/mode/load/serial_in/parallel_in pins to load each word, either serially or in one cycle.
- Optionally reads back the register's parallel_out after loading and flags mismatches. The check catches stuck faults that the register's single-bit correction cannot fix.

Parameters:
- WIDTH, 16, data width; must match the protected register; must be a multiple of 4 and at least 8.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  loader can accept a word.
- s_data  in  WIDTH  word to load.
- s_dir  in  1  serial direction: 0 = mode 00 (right shift, bit enters MSB); 1 = mode 01 (left shift, bit enters LSB).
- s_fast  in  1  1 = single-cycle parallel load (mode 11, load=1); overrides s_dir.
- reg_enable  out  1  to register enable.
- reg_mode  out  2  to register mode.
- reg_load  out  1  to register load.
- reg_serial_in  out  1  to register serial_in.
- reg_parallel_in  out  WIDTH  to register parallel_in.
- reg_parallel_out  in  WIDTH  from register parallel_out (already corrected).
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when a word load completes.
- mismatch  out  1  readback differed from the word; held until the next accepted word.

Behaviour:
- Reset: state IDLE, bit counter 0, shadow word 0, dir 0.
- Outputs during reset: every output listed is 0, including s_ready (s_ready = IDLE && !rst).
- Reset mid-operation aborts immediately; the partially shifted register contents are not restored.
- Output timing: all reg_* outputs, busy, done and mismatch decode from flops only; no combinational path from s_* to reg_*.
- When the loader is not driving a load: reg_enable=0, reg_mode=2'b11, reg_load=0, reg_serial_in=0, reg_parallel_in=0. Mode 11 with load=0 is a hold.
- IDLE:
  - s_ready=1.
  - On s_valid && s_ready: capture s_data into the shadow word, capture s_dir, clear mismatch, set counter to 0.
  - Go to LOAD if s_fast=1, otherwise SHIFT.
  - s_valid while not ready is ignored; the word is neither captured nor dropped-acknowledged.
- LOAD (1 cycle): reg_enable=1, reg_mode=11, reg_load=1, reg_parallel_in=shadow. Next state SETTLE.
- SHIFT (WIDTH cycles):
  - reg_enable=1, reg_mode = dir ? 01 : 00.
  - reg_serial_in = dir ? shadow[WIDTH-1-cnt] : shadow[cnt].
  - Counter increments each cycle.
  - When cnt == WIDTH-1, next state SETTLE and the counter wraps to 0.
- SETTLE (1 cycle): reg_enable=0, hold. Lets the register's syndrome logic see the final word and write back any correction.
- CHECK (1 cycle):
  - done=1.
  - mismatch <= (reg_parallel_out != shadow).
  - Next state IDLE.
- Latency, accept edge = cycle 0:
  - Serial: shifts in cycles 1..WIDTH, SETTLE in WIDTH+1, done in WIDTH+2; next acceptance possible at cycle WIDTH+3.
  - Fast: LOAD in cycle 1, SETTLE in 2, done in 3.
- Back-to-back words: a new word is accepted in the first IDLE cycle after CHECK; there is no bubble beyond that cycle.
- A single-bit upset inside the register during loading is corrected by the register and is not a mismatch.

Optional Feature:
- Macro: HAMMING_LOADER_READBACK_EN.
- Defined: SETTLE and CHECK exist as described above.
- Undefined:
  - SETTLE and CHECK are removed.
  - done pulses in the cycle immediately after the last SHIFT/LOAD cycle, which is also the IDLE cycle: serial done at cycle WIDTH+1, fast at cycle 2.
  - mismatch is tied to 0.
  - reg_parallel_out is unused.

Test Plan:
- Reset: assert rst mid-SHIFT (cnt=5) -> next cycle all outputs 0; after release s_ready=1, state IDLE.
- Serial right: s_data=16'hA5C3, s_dir=0, s_fast=0 -> reg_serial_in sequence is LSB first (1,1,0,0,0,0,1,1,...) over 16 enabled cycles with mode 00. Register parallel_out=16'hA5C3; done at cycle 18; mismatch=0.
- Serial left: s_data=16'h8001, s_dir=1 -> first serial bit 1, then fourteen 0s, then 1, with mode 01; final register value 16'h8001.
- Fast load: s_data=16'h1234, s_fast=1 -> one cycle with enable=1, mode=11, load=1, parallel_in=16'h1234; done at cycle 3.
- Readback fault (macro defined): bench forces reg_parallel_out=16'h1235 after a 16'h1234 load -> mismatch=1 at CHECK. mismatch stays 1 until the next accept, then clears.
- Handshake: s_valid held high for three words 16'h0001, 16'h0002, 16'h0003 -> exactly three accepts, each when s_ready=1; done pulses spaced WIDTH+3 cycles apart; no word lost or duplicated.
